// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
// Drives DIGITS active-low seven-segment digits from a per-digit loadable hex
// value. It also generates a divided clock and blinks selected digits.
//
// Parameters
//   DIGITS     : number of digits (1..8)
//   DIV        : clk_out half-period in mem_clk cycles (1..255)
//   BLINK_BITS : blink counter width; blink period is 2^BLINK_BITS cycles (2..32)
//
// Ports
//   mem_clk  in   sole clock, rising edge
//   resetn   in   synchronous active-low reset
//   clk_out  out  divided clock, period 2*DIV, 50% duty
//   ld_valid in   load request, always accepted
//   ld_data  in   4*DIGITS, digit i = ld_data[4i+3:4i]
//   ld_mask  in   DIGITS, per-digit write enable for a load
//   ld_ack   out  one-cycle pulse in the cycle after each ld_valid
//   blink_en in   DIGITS, per-digit blink enable
//   seg      out  7*DIGITS active-low segments, digit i = seg[7i+6:7i], bit0 = a
//
// Optional feature: define SEG_LZB_EN for leading-zero blanking (digit 0 never
// blanked). Blanking from this feature and from blink combine by OR.

module seg_display_ctrl #(
    parameter int unsigned DIGITS     = 6,
    parameter int unsigned DIV        = 1,
    parameter int unsigned BLINK_BITS = 24
) (
    input  logic                  mem_clk,
    input  logic                  resetn,
    output logic                  clk_out,
    input  logic                  ld_valid,
    input  logic [4*DIGITS-1:0]   ld_data,
    input  logic [DIGITS-1:0]     ld_mask,
    output logic                  ld_ack,
    input  logic [DIGITS-1:0]     blink_en,
    output logic [7*DIGITS-1:0]   seg
);

    localparam logic [7:0] DivLast = 8'(DIV - 1);

    logic [7:0]            r_div_cnt;
    logic                  r_clk_out;
    logic [BLINK_BITS-1:0] r_blink_cnt;
    logic [4*DIGITS-1:0]   r_nib;
    logic                  r_ld_ack;
    logic [7*DIGITS-1:0]   r_seg;

    logic                  w_phase;
    logic [DIGITS-1:0]     w_lzb_blank;
    logic [7*DIGITS-1:0]   w_seg_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

    // Clock divider: toggle clk_out each time the counter wraps.
    always_ff @(posedge mem_clk) begin
        if (!resetn) begin
            r_div_cnt <= 8'd0;
            r_clk_out <= 1'b0;
        end else if (r_div_cnt == DivLast) begin
            r_div_cnt <= 8'd0;
            r_clk_out <= ~r_clk_out;
        end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
        end
    end

    // Free-running blink counter; its MSB is the blink phase.
    always_ff @(posedge mem_clk) begin
        if (!resetn) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_BITS'(1);
        end
    end

    assign w_phase = r_blink_cnt[BLINK_BITS-1];

    // Load path: every ld_valid is accepted; masked-off digits hold.
    always_ff @(posedge mem_clk) begin
        if (!resetn) begin
            r_nib    <= '0;
            r_ld_ack <= 1'b0;
        end else begin
            r_ld_ack <= ld_valid;
            if (ld_valid) begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (ld_mask[i]) begin
                        r_nib[4*i +: 4] <= ld_data[4*i +: 4];
                    end
                end
            end
        end
    end

`ifdef SEG_LZB_EN
    logic w_lead;

    // Blank zeros from the top digit down until the first nonzero nibble.
    always_comb begin
        w_lzb_blank = '0;
        w_lead      = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (w_lead && (r_nib[4*i +: 4] == 4'd0)) begin
                w_lzb_blank[i] = 1'b1;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    assign w_lzb_blank = '0;
`endif

    always_comb begin
        w_seg_d = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if ((blink_en[i] && w_phase) || w_lzb_blank[i]) begin
                w_seg_d[7*i +: 7] = 7'h7F;
            end else begin
                w_seg_d[7*i +: 7] = hex_to_seg(r_nib[4*i +: 4]);
            end
        end
    end

    // Reset shows "0" on every digit regardless of blanking.
    always_ff @(posedge mem_clk) begin
        if (!resetn) begin
            r_seg <= {DIGITS{7'h40}};
        end else begin
            r_seg <= w_seg_d;
        end
    end

    assign clk_out = r_clk_out;
    assign ld_ack  = r_ld_ack;
    assign seg     = r_seg;

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter DIGITS, default 6: number of seven-segment digits driven, range 1..8.
REQ-002 Parameter DIV, default 1: clk_out half-period in mem_clk cycles, range 1..255.
REQ-003 Parameter BLINK_BITS, default 24: blink counter width; blink period is 2^BLINK_BITS mem_clk cycles, range 2..32.
REQ-004 mem_clk  input  1  sole clock; all flops on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 clk_out  output  1  divided clock for CPU/memory use.
REQ-007 ld_valid  input  1  load request for the display value.
REQ-008 ld_data  input  4*DIGITS  one hex nibble per digit; digit i = ld_data[4i+3:4i].
REQ-009 ld_mask  input  DIGITS  per-digit write enable for a load.
REQ-010 ld_ack  output  1  one-cycle pulse confirming an accepted load.
REQ-011 blink_en  input  DIGITS  per-digit blink enable, sampled every cycle.
REQ-012 seg  output  7*DIGITS  active-low segments; digit i = seg[7i+6:7i], bit 6 = g ... bit 0 = a.

Function
REQ-013 Divider: counter counts 0..DIV-1; at DIV-1 it SHALL wrap to 0 and toggle clk_out, giving period 2*DIV mem_clk cycles at 50% duty.
REQ-014 ld_valid is always accepted: on a cycle with ld_valid=1, each digit i with ld_mask[i]=1 SHALL latch its nibble; masked-off digits SHALL hold.
REQ-015 ld_ack SHALL be 1 exactly in the cycle after each cycle with ld_valid=1, including when ld_mask=0; back-to-back ld_valid yields back-to-back ld_ack.
REQ-016 Blink counter SHALL free-run, BLINK_BITS wide, wrapping from all-ones to 0; blink phase = counter MSB.
REQ-017 seg SHALL be registered: a latched nibble change appears on seg one cycle after it is latched, i.e. two cycles after ld_valid.
REQ-018 Encoding (hex of seg digit): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E.
REQ-019 If blink_en[i]=1 and blink phase=1, digit i SHALL output 7F (blank); otherwise it shows its encoding.
REQ-020 Divider, load path and blink counter SHALL operate independently; a load SHALL NOT disturb the divider or blink counter.

Reset
REQ-021 When resetn=0 at a mem_clk edge: divider counter=0, clk_out=0, blink counter=0, all nibbles=0, ld_ack=0, every seg digit=40 (shows "0").
REQ-022 ld_valid asserted in the same cycle as resetn=0 SHALL be ignored and SHALL NOT produce ld_ack.
REQ-023 Reset mid-period SHALL restart the divider, so the first clk_out rise occurs DIV cycles after resetn deasserts.

Configuration
REQ-024 Macro SEG_LZB_EN: when defined, leading-zero blanking SHALL apply: from the most-significant digit downward, every digit whose nibble is 0 SHALL output 7F until the first nonzero nibble; digit 0 SHALL never be blanked.
REQ-025 Without SEG_LZB_EN, all digits SHALL always display their nibble (subject only to blink); reset display = all digits 40.
REQ-026 Blanking from SEG_LZB_EN and from blink SHALL combine by OR; either one blanks the digit.

Verification
REQ-027 DIV=1, release reset -> clk_out 0,1,0,1 on successive cycles; DIV=3 -> 3 cycles low, 3 high.
REQ-028 DIGITS=6, ld_valid=1, ld_data=0x12AB3F, ld_mask=3F -> ld_ack next cycle; two cycles after load seg digits 5..0 = 79,24,08,03,30,0E.
REQ-029 After REQ-028, load ld_data=0x000000 with ld_mask=0x01 -> only digit 0 becomes 40; digits 5..1 unchanged.
REQ-030 BLINK_BITS=4, blink_en=0x02 -> digit 1 shows its code for 8 cycles and 7F for 8 cycles, repeating; other digits steady.
REQ-031 SEG_LZB_EN defined, load 0x000050 -> digits 5..2 = 7F, digit 1 = 12, digit 0 = 40; load 0x000000 -> digits 5..1 = 7F, digit 0 = 40.
REQ-032 Assert resetn=0 together with ld_valid=1 mid-blink -> no ld_ack; next cycle all seg digits 40, clk_out=0, blink restarts at phase 0.
